// File: rtl/deco_pipe.sv
// deco_pipe: pipelined instruction decode stage.
//
// Splits a 32-bit instruction into opcode/rd/rs/rt/imm fields, reads the two
// source operands from an internal register file and presents the decoded
// bundle in an output register with a valid/ready handshake. A per-register
// pending scoreboard stalls read-after-write hazards until the downstream
// writeback for the register arrives. After reset the register file is
// zeroed by a sequential sweep of 2**REG_AW cycles, during which no
// instruction is accepted.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid, in_ready, instr      fetch-side handshake and instruction
//   out_valid, out_ready           execute-side handshake
//   out_opcode, out_rd             decoded opcode and destination register
//   out_rs_val, out_rt_val         source operand values
//   out_imm                        sign-extended immediate
//   out_wr                         opcode writes rd (WR_MASK[opcode])
//   wb_en, wb_addr, wb_data        register file writeback
//   flush                          discard held and incoming instruction
//   stall_cnt                      saturating hazard-stall cycle counter
module deco_pipe #(
  parameter int          DATA_W  = 32,
  parameter int          REG_AW  = 7,
  parameter int          IMM_W   = 13,
  parameter logic [31:0] WR_MASK = 32'h0000_0062
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_opcode,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_rs_val,
  output logic [DATA_W-1:0] out_rt_val,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_wr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [15:0]       stall_cnt
);

  localparam int NREG  = 2 ** REG_AW;
  localparam int RD_HI = 26;
  localparam int RS_HI = 26 - REG_AW;
  localparam int RT_HI = 26 - 2 * REG_AW;

  // ---------------------------------------------------------------------
  // Field extraction
  // ---------------------------------------------------------------------
  logic [4:0]        opcode_in;
  logic [REG_AW-1:0] rd_in;
  logic [DATA_W-1:0] imm_in;
  logic [REG_AW-1:0] src_addr [2];   // [0] = rs, [1] = rt

  assign opcode_in   = instr[31:27];
  assign rd_in       = instr[RD_HI -: REG_AW];
  assign src_addr[0] = instr[RS_HI -: REG_AW];
  assign src_addr[1] = instr[RT_HI -: REG_AW];
  assign imm_in      = {{(DATA_W - IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic              clearing_reg;
  logic [REG_AW-1:0] clr_idx_reg;
  logic [NREG-1:0]   pend_reg;
  logic [NREG-1:0]   pend_next;

  logic              out_valid_reg;
  logic [4:0]        out_opcode_reg;
  logic [REG_AW-1:0] out_rd_reg;
  logic [DATA_W-1:0] out_imm_reg;
  logic              out_wr_reg;
  logic [1:0]        src_zero_reg;   // source was r0: operand reads as 0
  logic [1:0]        src_byp_reg;    // source was captured from writeback
  logic [DATA_W-1:0] byp_data_reg;
  logic [DATA_W-1:0] raw_reg [2];    // registered register-file read data
  logic [15:0]       stall_cnt_reg;

  logic [DATA_W-1:0] mem [NREG];

  // ---------------------------------------------------------------------
  // Hazard detection and bypass select
  // ---------------------------------------------------------------------
  logic              wb_live;
  logic [1:0]        src_haz;
  logic [1:0]        src_byp;
  logic              hazard;
  logic              accept;
  logic              out_fire;
  logic              commit;

  // Writebacks arriving while the file is being cleared are dropped.
  assign wb_live = wb_en & ~clearing_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic src_nz;
    logic wb_hit;
    assign src_nz  = (src_addr[gi] != '0);
    assign wb_hit  = wb_live & (wb_addr == src_addr[gi]);
    assign src_byp[gi] = src_nz & wb_hit;
    // A pending register is released by a same-cycle writeback; a writer
    // still sitting in the output register has not yet set its pend bit,
    // so it is checked directly.
    assign src_haz[gi] = src_nz &
                         ((pend_reg[src_addr[gi]] & ~wb_hit) |
                          (out_valid_reg & out_wr_reg & (out_rd_reg == src_addr[gi])));
  end

  assign hazard   = |src_haz;
  assign in_ready = ~clearing_reg & ~hazard & (~out_valid_reg | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid_reg & out_ready;
  // A bundle discarded by flush never reaches execute, so it must not mark
  // its destination as pending.
  assign commit   = out_fire & ~flush & out_wr_reg & (out_rd_reg != '0);

  // ---------------------------------------------------------------------
  // Scoreboard: set wins over a same-cycle clear of the same register.
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
    logic set_b;
    logic clr_b;
    assign set_b = commit & (out_rd_reg == REG_AW'(gi));
    assign clr_b = wb_live & (wb_addr == REG_AW'(gi));
    assign pend_next[gi] = set_b | (pend_reg[gi] & ~clr_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg <= '0;
    end else begin
      pend_reg <= pend_next;
    end
  end

  // ---------------------------------------------------------------------
  // Register file clear sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      clearing_reg <= 1'b1;
      clr_idx_reg  <= '0;
    end else if (clearing_reg) begin
      clr_idx_reg <= clr_idx_reg + 1'b1;
      if (clr_idx_reg == REG_AW'(NREG - 1)) begin
        clearing_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Register file: one write port, two registered read ports. Read data is
  // read-first; the same-cycle writeback case is handled by the bypass
  // select captured alongside it.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clearing_reg) begin
        mem[clr_idx_reg] <= '0;
      end else if (wb_en && (wb_addr != '0)) begin
        mem[wb_addr] <= wb_data;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    always_ff @(posedge clk) begin
      if (accept) begin
        raw_reg[gi] <= mem[src_addr[gi]];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_opcode_reg <= '0;
      out_rd_reg     <= '0;
      out_imm_reg    <= '0;
      out_wr_reg     <= 1'b0;
      src_zero_reg   <= 2'b11;   // forces both operand outputs to 0
      src_byp_reg    <= 2'b00;
      byp_data_reg   <= '0;
    end else begin
      if (flush) begin
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        out_valid_reg <= 1'b1;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end

      if (accept) begin
        out_opcode_reg  <= opcode_in;
        out_rd_reg      <= rd_in;
        out_imm_reg     <= imm_in;
        out_wr_reg      <= WR_MASK[opcode_in];
        src_zero_reg[0] <= (src_addr[0] == '0);
        src_zero_reg[1] <= (src_addr[1] == '0);
        src_byp_reg     <= src_byp;
        byp_data_reg    <= wb_data;
      end
    end
  end

  logic [DATA_W-1:0] src_val [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_val
    assign src_val[gi] = src_zero_reg[gi] ? '0 :
                         src_byp_reg[gi]  ? byp_data_reg :
                                            raw_reg[gi];
  end

  // ---------------------------------------------------------------------
  // Stall counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (in_valid && hazard && !flush && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_opcode = out_opcode_reg;
  assign out_rd     = out_rd_reg;
  assign out_rs_val = src_val[0];
  assign out_rt_val = src_val[1];
  assign out_imm    = out_imm_reg;
  assign out_wr     = out_wr_reg;
  assign stall_cnt  = stall_cnt_reg;

endmodule

// File: doc/deco_pipe.md
Name: deco_pipe

Overview:
Parametrised, pipelined successor of the combinational DECO decode block. It splits a 32-bit instruction into fields and reads two source operands from an internal register file. The register file accepts a writeback from the downstream stage. A per-register scoreboard stalls read-after-write hazards, and the decoded bundle is held in an output register with a valid/ready handshake. The block sits between fetch and execute.

Parameters:
DATA_W, 32, width of register data, writeback data and sign-extended immediate
REG_AW, 7, register address width; the register file has 2**REG_AW entries
IMM_W, 13, immediate field width taken from instr[IMM_W-1:0]; must be less than or equal to 32-5-2*REG_AW
WR_MASK, 32'h0000_0062, bit i set means opcode i writes rd (default: opcodes 1 Lv, 5 Sum, 6 Cp)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instr is valid
in_ready  out  1  stage accepts instr this cycle
instr  in  32  instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes bundle
out_opcode  out  5  instr[31:27]
out_rd  out  REG_AW  destination field
out_rs_val  out  DATA_W  value of register rs
out_rt_val  out  DATA_W  value of register rt
out_imm  out  DATA_W  sign-extended immediate
out_wr  out  1  WR_MASK[opcode]
wb_en  in  1  writeback strobe
wb_addr  in  REG_AW  writeback register
wb_data  in  DATA_W  writeback value
flush  in  1  discard held and incoming instruction
stall_cnt  out  16  hazard-stall cycle counter, saturating

Behaviour:
- Instruction fields: opcode=[31:27], rd=[26:27-REG_AW], rs=next REG_AW bits below rd, rt=next REG_AW bits below rs, imm=[IMM_W-1:0] sign-extended to DATA_W.
- Register file: 2**REG_AW x DATA_W. Reg 0 always reads 0; writes to reg 0 are ignored. Write on the rising edge when wb_en=1.
- Write-through bypass: if wb_en=1 and wb_addr equals a source address, that source is captured as wb_data in the same cycle (except address 0).
- Scoreboard: one pending bit per register.
  - Set pend[rd] on an out_valid & out_ready handshake with out_wr=1 and rd!=0.
  - Clear pend[wb_addr] on wb_en.
  - If set and clear hit the same register in the same cycle, the bit stays set.
- Hazard: for rs or rt (each nonzero), a hazard exists if either condition holds:
  - pend[src]=1 and not (wb_en & wb_addr==src);
  - out_valid=1, out_wr=1 and out_rd==src (this covers an older writer still held in the output register).
- in_ready = !hazard & (!out_valid | out_ready) & !flush. The hazard term uses the instr currently presented.
- Accept when in_valid & in_ready. Decoded fields and operands are registered, and out_valid=1 on the next cycle. Latency is 1 cycle.
- If an out handshake occurs with no accept in the same cycle, out_valid goes to 0.
- Output fields are held stable while out_valid & !out_ready.
- flush=1: out_valid goes to 0 next cycle and nothing is accepted. The scoreboard is unchanged because the flushed bundle never handshook. Writebacks still apply.
- stall_cnt increments each cycle with in_valid & hazard & !flush, and saturates at 16'hFFFF.
- Reset (synchronous):
  - out_valid=0; all pend bits=0; stall_cnt=0.
  - out_* data fields=0.
  - Register file contents are zeroed, via a sequential clear over 2**REG_AW cycles with in_ready=0 during the clear.
  - Reset asserted mid-clear restarts the clear.
  - Writebacks during the clear are ignored.

Test Plan:
- Reset, then wait 128 cycles: in_ready is 0 for all 128 cycles and then 1; every register reads 0; stall_cnt=0.
- Present Lv 32'h080402F3 with out_ready=1: one cycle later out_valid=1, out_opcode=1, out_wr=1, fields match the bit slicing, and out_imm is correctly sign-extended.
- Independent back-to-back (RAW-free) instructions with out_ready=1: one accept per cycle and no bubbles. With out_ready=0 for 3 cycles: out_* stay stable and in_ready=0.
- Sum writing r10, then a Cp reading r10: in_ready=0 and stall_cnt increments until wb_en=1, wb_addr=10, wb_data=10. In that same cycle the Cp is accepted, and its out_rs_val=10 on the following cycle.
- Writeback to r61 with value 10 in the same cycle a reader of r61 is accepted: the reader captures 10 via bypass. Writeback to r0: r0 still reads 0.
- flush while out_valid=1 holds a writer to r5: out_valid goes to 0, pend[5] stays 0, and a subsequent reader of r5 issues without stalling.
